// File: rtl/pong_ram_arbiter.sv
// pong_ram_arbiter
// Two-master arbiter in front of a single-port, fixed-latency-1 RAM.
// Master 0 is the CPU and master 1 is the video engine.
// Contention is resolved round-robin, with a bounded run (HOLD_MAX grants)
// for the current owner.
// Read data returns exactly one cycle after issue and is steered back to the
// master that issued the read.
// Optional build macro PONG_RAM_ARB_VIDEO_PRI_EN:
//   - when defined, video wins every contended cycle;
//   - the hold counter stays at zero.
module pong_ram_arbiter #(
    parameter int ADDR_W   = 12,
    parameter int DATA_W   = 32,
    parameter int HOLD_MAX = 4      // legal range 1..15
) (
    input  logic                clk,
    input  logic                reset_n,

    // master 0 (CPU)
    input  logic [ADDR_W-1:0]   m0_address,
    input  logic [DATA_W/8-1:0] m0_byteenable,
    input  logic                m0_read,
    input  logic                m0_write,
    input  logic [DATA_W-1:0]   m0_writedata,
    output logic                m0_waitrequest,
    output logic [DATA_W-1:0]   m0_readdata,
    output logic                m0_readdatavalid,

    // master 1 (video)
    input  logic [ADDR_W-1:0]   m1_address,
    input  logic [DATA_W/8-1:0] m1_byteenable,
    input  logic                m1_read,
    input  logic                m1_write,
    input  logic [DATA_W-1:0]   m1_writedata,
    output logic                m1_waitrequest,
    output logic [DATA_W-1:0]   m1_readdata,
    output logic                m1_readdatavalid,

    // RAM slave
    output logic [ADDR_W-1:0]   ram_address,
    output logic [DATA_W/8-1:0] ram_byteenable,
    output logic [DATA_W-1:0]   ram_writedata,
    output logic                ram_chipselect,
    output logic                ram_write,
    output logic                ram_clken,
    input  logic [DATA_W-1:0]   ram_readdata
);

    localparam logic [3:0] HOLD_LIM = 4'(HOLD_MAX);

    typedef enum logic {
        MASTER_CPU   = 1'b0,
        MASTER_VIDEO = 1'b1
    } master_e;

    master_e             owner;
    master_e             grant;
    logic [3:0]          hold_cnt;
    logic                req0;
    logic                req1;
    logic                issue;
    logic                issue_ok;
    logic                issue_write;
    logic                pend_valid;
    master_e             pend_tag;
    logic [DATA_W-1:0]   rd_hold0;
    logic [DATA_W-1:0]   rd_hold1;

    // Pick this cycle's winner from the request lines, the owner and the hold count
    always_comb begin
        req0  = m0_read | m0_write;
        req1  = m1_read | m1_write;
        issue = req0 | req1;
        grant = MASTER_CPU;
        if (req0 && req1) begin
`ifdef PONG_RAM_ARB_VIDEO_PRI_EN
            grant = MASTER_VIDEO;
`else
            // The owner keeps the RAM until it has used up its run.
            // After that, the waiting master takes over.
            if (hold_cnt >= HOLD_LIM) begin
                grant = (owner == MASTER_CPU) ? MASTER_VIDEO : MASTER_CPU;
            end else begin
                grant = owner;
            end
`endif
        end else if (req1) begin
            grant = MASTER_VIDEO;
        end
    end

    // Nothing may be accepted or driven onto the RAM while reset is held
    assign issue_ok    = issue & reset_n;
    assign issue_write = (grant == MASTER_VIDEO) ? m1_write : m0_write;

    assign m0_waitrequest = !(issue_ok && (grant == MASTER_CPU));
    assign m1_waitrequest = !(issue_ok && (grant == MASTER_VIDEO));

    assign ram_address    = (grant == MASTER_VIDEO) ? m1_address    : m0_address;
    assign ram_byteenable = (grant == MASTER_VIDEO) ? m1_byteenable : m0_byteenable;
    assign ram_writedata  = (grant == MASTER_VIDEO) ? m1_writedata  : m0_writedata;
    assign ram_chipselect = issue_ok;
    assign ram_write      = issue_ok & issue_write;
    assign ram_clken      = reset_n;

    // Track the last granted master and the length of its current run
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            owner    <= MASTER_CPU;
            hold_cnt <= 4'd0;
        end else if (issue) begin
            owner <= grant;
`ifdef PONG_RAM_ARB_VIDEO_PRI_EN
            hold_cnt <= 4'd0;
`else
            if (grant == owner) begin
                // Saturate so that a long solo run cannot wrap back under the limit
                hold_cnt <= (hold_cnt == 4'hF) ? hold_cnt : hold_cnt + 4'd1;
            end else begin
                hold_cnt <= 4'd1;
            end
`endif
        end else begin
            hold_cnt <= 4'd0;
        end
    end

    // Remember which master owns the read that is in flight through the RAM
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pend_valid <= 1'b0;
            pend_tag   <= MASTER_CPU;
        end else begin
            pend_valid <= issue & ~issue_write;
            if (issue) begin
                pend_tag <= grant;
            end
        end
    end

    // Capture returned data so that each master's readdata holds between responses
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rd_hold0 <= '0;
            rd_hold1 <= '0;
        end else if (pend_valid) begin
            if (pend_tag == MASTER_CPU) begin
                rd_hold0 <= ram_readdata;
            end else begin
                rd_hold1 <= ram_readdata;
            end
        end
    end

    // The response is presented in the cycle the RAM delivers it.
    // Between responses, the held copy is shown instead.
    assign m0_readdatavalid = pend_valid && (pend_tag == MASTER_CPU);
    assign m1_readdatavalid = pend_valid && (pend_tag == MASTER_VIDEO);
    assign m0_readdata      = m0_readdatavalid ? ram_readdata : rd_hold0;
    assign m1_readdata      = m1_readdatavalid ? ram_readdata : rd_hold1;

endmodule

// File: tb/tb_pong_ram_arbiter.sv
// Testbench for pong_ram_arbiter.
// Directed scenarios are followed by randomized traffic.
// All traffic is checked against a grant/memory reference model.
module tb_pong_ram_arbiter;

    localparam int ADDR_W   = 12;
    localparam int DATA_W   = 32;
    localparam int HOLD_MAX = 4;

    typedef struct packed {
        logic        rd;
        logic        wr;
        logic [11:0] addr;
        logic [3:0]  be;
        logic [31:0] data;
    } cmd_t;

    logic               clk = 1'b0;
    logic               reset_n;
    logic [ADDR_W-1:0]  m0_address, m1_address;
    logic [3:0]         m0_byteenable, m1_byteenable;
    logic               m0_read, m0_write, m1_read, m1_write;
    logic [31:0]        m0_writedata, m1_writedata;
    logic               m0_waitrequest, m1_waitrequest;
    logic [31:0]        m0_readdata, m1_readdata;
    logic               m0_readdatavalid, m1_readdatavalid;
    logic [ADDR_W-1:0]  ram_address;
    logic [3:0]         ram_byteenable;
    logic [31:0]        ram_writedata;
    logic               ram_chipselect, ram_write, ram_clken;
    logic [31:0]        ramReadData = 32'h0;

    int compareCount  = 0;
    int mismatchCount = 0;

    // reference model state
    logic [31:0] refMem [0:4095];
    logic [31:0] ramMem [0:4095];
    int          lastOwner;
    int          histQ[$];
    bit          pendValid;
    int          pendMaster;
    logic [31:0] pendData;
    logic [31:0] expHold [2];
    int          obsGrant;

    pong_ram_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .HOLD_MAX(HOLD_MAX)) dut (
        .clk(clk), .reset_n(reset_n),
        .m0_address(m0_address), .m0_byteenable(m0_byteenable), .m0_read(m0_read),
        .m0_write(m0_write), .m0_writedata(m0_writedata), .m0_waitrequest(m0_waitrequest),
        .m0_readdata(m0_readdata), .m0_readdatavalid(m0_readdatavalid),
        .m1_address(m1_address), .m1_byteenable(m1_byteenable), .m1_read(m1_read),
        .m1_write(m1_write), .m1_writedata(m1_writedata), .m1_waitrequest(m1_waitrequest),
        .m1_readdata(m1_readdata), .m1_readdatavalid(m1_readdatavalid),
        .ram_address(ram_address), .ram_byteenable(ram_byteenable),
        .ram_writedata(ram_writedata), .ram_chipselect(ram_chipselect),
        .ram_write(ram_write), .ram_clken(ram_clken), .ram_readdata(ramReadData)
    );

    always #5 clk = ~clk;

    // Behavioural single-port RAM slave with one cycle of read latency
    always @(posedge clk) begin
        if (ram_clken && ram_chipselect) begin
            if (ram_write) begin
                for (int b = 0; b < 4; b++)
                    if (ram_byteenable[b]) ramMem[ram_address][b*8 +: 8] <= ram_writedata[b*8 +: 8];
            end else begin
                ramReadData <= ramMem[ram_address];
            end
        end
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        compareCount++;
        if (observed !== expected) begin
            mismatchCount++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, observed, expected);
        end
    endtask

    function automatic cmd_t idleCmd();
        cmd_t c = '0;
        return c;
    endfunction

    function automatic cmd_t mkCmd(input bit rd, input bit wr, input logic [11:0] a,
                                   input logic [3:0] be, input logic [31:0] d);
        cmd_t c;
        c.rd = rd; c.wr = wr; c.addr = a; c.be = be; c.data = d;
        return c;
    endfunction

    function automatic cmd_t randCmd();
        cmd_t c;
        int k = $urandom_range(0, 9);
        c.rd   = (k < 4);
        c.wr   = (k >= 4 && k < 7);
        c.addr = 12'h100 + 12'($urandom_range(0, 15));
        c.be   = 4'($urandom_range(1, 15));
        c.data = $urandom;
        return c;
    endfunction

    // Length of the owner's current unbroken run of grants
    function automatic int runLength();
        int n = 0;
        for (int i = histQ.size() - 1; i >= 0; i--) begin
            if (histQ[i] != lastOwner) break;
            n++;
        end
        return n;
    endfunction

    function automatic int predictGrant(input bit r0, input bit r1);
        if (!r0 && !r1) return -1;
        if (r0 && !r1)  return 0;
        if (!r0 && r1)  return 1;
`ifdef PONG_RAM_ARB_VIDEO_PRI_EN
        return 1;
`else
        return (runLength() >= HOLD_MAX) ? 1 - lastOwner : lastOwner;
`endif
    endfunction

    task automatic resetModel();
        lastOwner  = 0;
        histQ      = {};
        pendValid  = 0;
        pendMaster = 0;
        expHold[0] = '0;
        expHold[1] = '0;
    endtask

    task automatic driveInputs(input cmd_t c0, input cmd_t c1);
        m0_read = c0.rd; m0_write = c0.wr; m0_address = c0.addr;
        m0_byteenable = c0.be; m0_writedata = c0.data;
        m1_read = c1.rd; m1_write = c1.wr; m1_address = c1.addr;
        m1_byteenable = c1.be; m1_writedata = c1.data;
    endtask

    // One bus cycle.
    // First check the return path of the previous cycle.
    // Then present new commands and check the issue path.
    task automatic applyStimulus(input cmd_t c0, input cmd_t c1);
        int   g;
        cmd_t ic;
        @(negedge clk);
        checkOutput("m0_rdvalid", 32'(m0_readdatavalid), 32'(pendValid && pendMaster == 0));
        checkOutput("m1_rdvalid", 32'(m1_readdatavalid), 32'(pendValid && pendMaster == 1));
        if (pendValid) expHold[pendMaster] = pendData;
        checkOutput("m0_readdata", m0_readdata, expHold[0]);
        checkOutput("m1_readdata", m1_readdata, expHold[1]);
        pendValid = 0;
        driveInputs(c0, c1);
        #1;
        g = predictGrant(c0.rd | c0.wr, c1.rd | c1.wr);
        obsGrant = !m0_waitrequest ? 0 : (!m1_waitrequest ? 1 : -1);
        checkOutput("m0_waitreq", 32'(m0_waitrequest), 32'(g != 0));
        checkOutput("m1_waitreq", 32'(m1_waitrequest), 32'(g != 1));
        checkOutput("ram_cs", 32'(ram_chipselect), 32'(g >= 0));
        checkOutput("ram_clken", 32'(ram_clken), 32'd1);
        if (g >= 0) begin
            ic = (g == 1) ? c1 : c0;
            checkOutput("ram_write", 32'(ram_write), 32'(ic.wr));
            checkOutput("ram_addr", 32'(ram_address), 32'(ic.addr));
            checkOutput("ram_be", 32'(ram_byteenable), 32'(ic.be));
            if (ic.wr) begin
                checkOutput("ram_wdata", ram_writedata, ic.data);
                for (int b = 0; b < 4; b++)
                    if (ic.be[b]) refMem[ic.addr][b*8 +: 8] = ic.data[b*8 +: 8];
            end else begin
                pendValid  = 1;
                pendMaster = g;
                pendData   = refMem[ic.addr];
            end
            lastOwner = g;
        end
        histQ.push_back(g);
        if (histQ.size() > 32) void'(histQ.pop_front());
    endtask

    task automatic checkResetValues();
        checkOutput("rst_m0_waitreq", 32'(m0_waitrequest), 32'd1);
        checkOutput("rst_m1_waitreq", 32'(m1_waitrequest), 32'd1);
        checkOutput("rst_m0_rdvalid", 32'(m0_readdatavalid), 32'd0);
        checkOutput("rst_m1_rdvalid", 32'(m1_readdatavalid), 32'd0);
        checkOutput("rst_m0_readdata", m0_readdata, 32'd0);
        checkOutput("rst_m1_readdata", m1_readdata, 32'd0);
        checkOutput("rst_ram_cs", 32'(ram_chipselect), 32'd0);
        checkOutput("rst_ram_write", 32'(ram_write), 32'd0);
        checkOutput("rst_ram_clken", 32'(ram_clken), 32'd0);
    endtask

    // Hold reset with both masters requesting.
    // Release it just after a rising edge, with the bus idle.
    task automatic doReset(input int cycles);
        reset_n = 1'b0;
        driveInputs(mkCmd(1, 0, 12'h001, 4'hF, 32'h0), mkCmd(1, 0, 12'h002, 4'hF, 32'h0));
        #1;
        checkResetValues();
        repeat (cycles) @(posedge clk);
        #1;
        checkResetValues();
        driveInputs(idleCmd(), idleCmd());
        #1;
        reset_n = 1'b1;
        resetModel();
    endtask

    initial begin
        int pat [12];
        for (int i = 0; i < 4096; i++) begin
            refMem[i] = '0;
            ramMem[i] = '0;
        end
        resetModel();
        doReset(3);

        // single write then read-back on master 0
        applyStimulus(mkCmd(0, 1, 12'h010, 4'hF, 32'hDEADBEEF), idleCmd());
        checkOutput("req032_wr_accept", 32'(obsGrant), 32'd0);
        applyStimulus(mkCmd(1, 0, 12'h010, 4'hF, 32'h0), idleCmd());
        checkOutput("req032_rd_accept", 32'(obsGrant), 32'd0);
        applyStimulus(idleCmd(), idleCmd());
        checkOutput("req032_data", m0_readdata, 32'hDEADBEEF);

        // byte-lane write over existing word on master 1
        applyStimulus(idleCmd(), mkCmd(0, 1, 12'h7FF, 4'hF, 32'h11223344));
        applyStimulus(idleCmd(), mkCmd(0, 1, 12'h7FF, 4'h1, 32'h000000AA));
        applyStimulus(idleCmd(), mkCmd(1, 0, 12'h7FF, 4'hF, 32'h0));
        applyStimulus(idleCmd(), idleCmd());
        checkOutput("req033_data", m1_readdata, 32'h112233AA);

        // continuous contention starting from owner 0 with an empty hold count
        applyStimulus(mkCmd(1, 0, 12'h010, 4'hF, 32'h0), idleCmd());
        applyStimulus(idleCmd(), idleCmd());
`ifdef PONG_RAM_ARB_VIDEO_PRI_EN
        pat = '{1, 1, 1, 1, 1, 1, 1, 1, 1, 1, 1, 1};
`else
        pat = '{0, 0, 0, 0, 1, 1, 1, 1, 0, 0, 0, 0};
`endif
        for (int i = 0; i < 12; i++) begin
            applyStimulus(mkCmd(1, 0, 12'h010, 4'hF, 32'h0), mkCmd(1, 0, 12'h7FF, 4'hF, 32'h0));
            checkOutput($sformatf("req034_grant%0d", i), 32'(obsGrant), 32'(pat[i]));
        end
        applyStimulus(idleCmd(), idleCmd());

`ifdef PONG_RAM_ARB_VIDEO_PRI_EN
        // video keeps the RAM for as long as it asks
        for (int i = 0; i < 10; i++) begin
            applyStimulus(mkCmd(1, 0, 12'h010, 4'hF, 32'h0), mkCmd(1, 0, 12'h7FF, 4'hF, 32'h0));
            checkOutput($sformatf("req036_grant%0d", i), 32'(obsGrant), 32'd1);
            checkOutput($sformatf("req036_m0wait%0d", i), 32'(m0_waitrequest), 32'd1);
        end
        applyStimulus(mkCmd(1, 0, 12'h010, 4'hF, 32'h0), idleCmd());
        checkOutput("req036_m0_after", 32'(obsGrant), 32'd0);
        applyStimulus(idleCmd(), idleCmd());
`endif

        // reset in the cycle the m1 response would be returned
        applyStimulus(idleCmd(), mkCmd(1, 0, 12'h7FF, 4'hF, 32'h0));
        @(posedge clk);
        #1;
        doReset(2);
        applyStimulus(mkCmd(1, 0, 12'h010, 4'hF, 32'h0), idleCmd());
        checkOutput("req035_m0_first", 32'(obsGrant), 32'd0);
        checkOutput("req035_no_m1_rdv", 32'(m1_readdatavalid), 32'd0);
        applyStimulus(idleCmd(), idleCmd());

        // randomized mixed traffic, with occasional fully idle cycles
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 7) == 0) applyStimulus(idleCmd(), idleCmd());
            else applyStimulus(randCmd(), randCmd());
        end
        applyStimulus(idleCmd(), idleCmd());
        applyStimulus(idleCmd(), idleCmd());

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, mismatchCount);
        $finish;
    end

endmodule

// File: doc/pong_ram_arbiter.md
PONG_RAM_ARBITER -- requirements
Module: pong_ram_arbiter

Interface
REQ-001 Parameter ADDR_W, default 12, meaning RAM word-address width.
REQ-002 Parameter DATA_W, default 32, meaning data width; byteenable width SHALL be DATA_W/8.
REQ-003 Parameter HOLD_MAX, default 4, meaning maximum consecutive grants to one master while the other is requesting; legal range 1-15.
REQ-004 clk  in  1  sole clock; all state updates on its rising edge.
REQ-005 reset_n  in  1  asynchronous, active-low reset.
REQ-006 mN_address  in  ADDR_W  master N word address (N = 0 CPU, 1 video).
REQ-007 mN_byteenable  in  DATA_W/8  master N byte lanes.
REQ-008 mN_read, mN_write  in  1 each  master N request strobes; simultaneous read and write is illegal.
REQ-009 mN_writedata  in  DATA_W  master N write data.
REQ-010 mN_waitrequest  out  1  high = master N command not accepted this cycle.
REQ-011 mN_readdata  out  DATA_W  master N read data.
REQ-012 mN_readdatavalid  out  1  one-cycle pulse qualifying mN_readdata.
REQ-013 ram_address, ram_byteenable, ram_writedata  out  ADDR_W, DATA_W/8, DATA_W  command to RAM slave.
REQ-014 ram_chipselect, ram_write, ram_clken  out  1 each  RAM strobes and clock enable.
REQ-015 ram_readdata  in  DATA_W  RAM output, valid the cycle after the read command edge (fixed latency 1).

Function
REQ-016 A command SHALL be accepted from master N in any cycle in which it requests and is selected; acceptance is signalled by mN_waitrequest low in that cycle, and the RAM command is driven in the same cycle.
REQ-017 mN_waitrequest SHALL be low only when master N is requesting and selected; when not requesting it SHALL be high.
REQ-018 At most one command SHALL be issued per cycle; ram_chipselect = 1 exactly in issue cycles, ram_write = issued mN_write.
REQ-019 ram_clken SHALL be 1 at all times out of reset.
REQ-020 Selection: if only one master requests, it wins; if both request, the winner is the owner (last-granted master) unless its hold counter has reached HOLD_MAX, in which case the other master wins.
REQ-021 Hold counter (4 bits) SHALL increment on each grant to the current owner, reset to 1 when ownership changes, and reset to 0 on any idle cycle (no request).
REQ-022 Owner register SHALL update at the edge ending every issue cycle to the granted master.
REQ-023 Read return: on a read issue a 1-bit pending-valid and 1-bit tag SHALL be registered; the next cycle ram_readdata SHALL be routed to mTAG_readdata with mTAG_readdatavalid = 1, all other readdatavalid = 0.
REQ-024 Back-to-back reads (either master, any interleaving) SHALL sustain one read per cycle with each response delivered exactly one cycle after its issue, in order.
REQ-025 A write SHALL produce no readdatavalid.
REQ-026 mN_readdata SHALL hold its last value when readdatavalid is 0.
REQ-027 Commands from master N SHALL NOT be reordered; address, byteenable and writedata SHALL pass unmodified.

Reset
REQ-028 While reset_n = 0: owner = 0 (CPU), hold counter = 0, pending-valid = 0, both mN_waitrequest = 1, mN_readdatavalid = 0, mN_readdata = 0, ram_chipselect = 0, ram_write = 0, ram_clken = 0.
REQ-029 Reset asserted with a read pending SHALL discard the response; no readdatavalid SHALL appear after reset release.
REQ-030 First command SHALL be accepted no earlier than the first rising edge after reset_n deassertion.

Configuration
REQ-031 Macro PONG_RAM_ARB_VIDEO_PRI_EN: when defined, master 1 (video) SHALL win every contended cycle (REQ-020/021 hold logic bypassed, counter tied to 0); when undefined, REQ-020/021 round-robin-with-hold applies.

Verification
REQ-032 Single write m0 addr 0x010 data 0xDEADBEEF be 0xF, then m0 read 0x010 -> m0_waitrequest low both cycles, m0_readdatavalid one cycle after read issue with 0xDEADBEEF.
REQ-033 Byte write m1 addr 0x7FF data 0x000000AA be 0x1 over prior 0x11223344, read back -> 0x112233AA on m1_readdata.
REQ-034 Both masters read continuously for 12 cycles, HOLD_MAX = 4, owner 0 -> grant pattern 0,0,0,0,1,1,1,1,0,0,0,0; each master's readdatavalid exactly one cycle after each own grant, never to the other master.
REQ-035 reset_n pulled low the cycle after an m1 read issue -> no m1_readdatavalid; all outputs at REQ-028 values; post-release m0 request accepted first cycle.
REQ-036 With PONG_RAM_ARB_VIDEO_PRI_EN defined, both masters request for 10 cycles -> m1 granted all 10, m0_waitrequest high throughout, m0 granted in cycle after m1 drops request.
